// File: rtl/bus_switch_multi.sv
// Multi-window bus switch: lowest-index address window wins, per-channel wait states, ready/error handshake.
// Optional write protection of channels flagged in RO_MASK is enabled by defining BUS_SWITCH_WRITE_PROTECT_EN.
module bus_switch_multi #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int NCH    = 4,
  parameter logic [NCH*ADDR_W-1:0] MASKS   = '0,
  parameter logic [NCH*ADDR_W-1:0] COMPS   = '0,
  parameter logic [NCH*4-1:0]      WAITS   = '0,
  parameter logic [NCH-1:0]        RO_MASK = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  inout  wire  [DATA_W-1:0]     data,
  input  logic                  loadEnable,
  input  logic                  outputEnable,
  input  logic [NCH*DATA_W-1:0] data_from_storage,
  output logic [DATA_W-1:0]     data_to_storage,
  output logic [NCH-1:0]        load_out,
  output logic [NCH-1:0]        match,
  output logic                  ready,
  output logic                  error
);

  // state  | meaning
  // IDLE   | waiting for a single read or write request
  // WAIT   | counting down the selected channel's wait states
  // ACCESS | one-cycle write strobe / read capture
  // DONE   | ready (and possibly error) held until both requests drop
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NCH-1:0]      match_q, match_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                is_read_q, is_read_d;
  logic                error_q, error_d;

  logic [NCH-1:0]      hit;
  logic [NCH-1:0]      sel;
  logic [3:0]          sel_wait;
  logic [DATA_W-1:0]   rd_sel;
  logic                drive_data;

  always_comb begin
    hit      = '0;
    sel      = '0;
    sel_wait = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = ((address & MASKS[i*ADDR_W +: ADDR_W]) == COMPS[i*ADDR_W +: ADDR_W]);
    end
    // Walk downwards so the lowest hitting index is the one left standing.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel      = '0;
        sel[i]   = 1'b1;
        sel_wait = WAITS[i*4 +: 4];
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (match_q[i]) rd_sel = rd_sel | data_from_storage[i*DATA_W +: DATA_W];
    end
  end

`ifndef BUS_SWITCH_WRITE_PROTECT_EN
  logic unused_ro_mask;
  assign unused_ro_mask = ^RO_MASK;
`endif

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    error_d   = error_q;
    load_out  = '0;
    case (state_q)
      S_IDLE: begin
        if (loadEnable ^ outputEnable) begin
          match_d   = sel;
          is_read_d = outputEnable;
          if (loadEnable) wr_data_d = data;
          if (sel == '0) begin
            state_d = S_DONE;
            error_d = 1'b1;
          end
`ifdef BUS_SWITCH_WRITE_PROTECT_EN
          else if (loadEnable && |(sel & RO_MASK)) begin
            state_d = S_DONE;
            error_d = 1'b1;
          end
`endif
          else if (sel_wait == 4'd0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = sel_wait;
          end
        end else if (loadEnable && outputEnable) begin
          state_d = S_DONE;
          error_d = 1'b1;
          match_d = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (is_read_q) rdata_d = rd_sel;
        else           load_out = match_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!loadEnable && !outputEnable) begin
          state_d = S_IDLE;
          match_d = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      match_q   <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      is_read_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      error_q   <= error_d;
    end
  end

  assign drive_data      = (state_q == S_DONE) && is_read_q && !error_q && outputEnable;
  assign data            = drive_data ? rdata_q : {DATA_W{1'bz}};
  assign data_to_storage = wr_data_q;
  assign match           = match_q;
  assign ready           = (state_q == S_DONE);
  assign error           = error_q;

endmodule

// File: tb/tb_bus_switch_multi.sv
// Directed bench for bus_switch_multi with three windows; the data bus is pulled high so a released bus reads FFFF.
module tb_bus_switch_multi;

  localparam logic [15:0] REL = 16'hFFFF;

  logic        clk;
  logic        reset;
  logic [23:0] address;
  tri1  [15:0] data;
  logic        le;
  logic        oe;
  logic [47:0] dfs;
  logic [15:0] dts;
  logic [2:0]  load_out;
  logic [2:0]  match;
  logic        ready;
  logic        error;

  logic        tb_drv;
  logic [15:0] tb_wdata;
  int          n_chk;
  int          n_fail;
  int          lo_cnt [3];

  assign data = tb_drv ? tb_wdata : 16'hzzzz;

  bus_switch_multi #(
    .ADDR_W (24),
    .DATA_W (16),
    .NCH    (3),
    .MASKS  ({24'hfff000, 24'hffc000, 24'hfff000}),
    .COMPS  ({24'h100000, 24'h03c000, 24'h03f000}),
    .WAITS  ({4'd1, 4'd2, 4'd0}),
    .RO_MASK(3'b010)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .address          (address),
    .data             (data),
    .loadEnable       (le),
    .outputEnable     (oe),
    .data_from_storage(dfs),
    .data_to_storage  (dts),
    .load_out         (load_out),
    .match            (match),
    .ready            (ready),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (load_out[i]) lo_cnt[i]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 3; i++) lo_cnt[i] = 0;
    reset = 1'b0; le = 1'b0; oe = 1'b0; tb_drv = 1'b0; tb_wdata = '0;
    address = '0;
    dfs = {16'hbeef, 16'h1234, 16'hdead};
    tick(); tick();
    check("rst_match", {13'd0, match}, 16'h0);
    check("rst_load", {13'd0, load_out}, 16'h0);
    check("rst_ready", {15'd0, ready}, 16'h0);
    check("rst_error", {15'd0, error}, 16'h0);
    check("rst_dts", dts, 16'h0);
    check("rst_data", data, REL);
    reset = 1'b1;
    tick();

    // write hitting ch0 and ch1: ch0 wins, no wait states
    address = 24'h03f010; tb_wdata = 16'hA5A5; tb_drv = 1'b1; le = 1'b1;
    tick();
    check("wr_match", {13'd0, match}, 16'h0001);
    check("wr_load", {13'd0, load_out}, 16'h0001);
    check("wr_ready_early", {15'd0, ready}, 16'h0);
    check("wr_dts", dts, 16'hA5A5);
    tb_wdata = 16'h0000; address = 24'h000000;
    tick();
    check("wr_ready", {15'd0, ready}, 16'h1);
    check("wr_load_end", {13'd0, load_out}, 16'h0);
    check("wr_error", {15'd0, error}, 16'h0);
    tick();
    check("wr_hold_ready", {15'd0, ready}, 16'h1);
    le = 1'b0; tb_drv = 1'b0;
    tick();
    check("wr_idle_ready", {15'd0, ready}, 16'h0);
    check("wr_idle_match", {13'd0, match}, 16'h0);
    check("wr_dts_hold", dts, 16'hA5A5);
    check("wr_lo0_cnt", 16'(lo_cnt[0]), 16'd1);
    check("wr_lo1_cnt", 16'(lo_cnt[1]), 16'd0);

    // read ch1 with two wait states
    address = 24'h03c100; oe = 1'b1;
    tick();
    check("rd1_match", {13'd0, match}, 16'h0002);
    check("rd1_ready_e1", {15'd0, ready}, 16'h0);
    tick();
    check("rd1_ready_e2", {15'd0, ready}, 16'h0);
    tick();
    check("rd1_ready_e3", {15'd0, ready}, 16'h0);
    check("rd1_data_e3", data, REL);
    tick();
    check("rd1_ready_e4", {15'd0, ready}, 16'h1);
    check("rd1_error", {15'd0, error}, 16'h0);
    check("rd1_data", data, 16'h1234);
    tick();
    check("rd1_data_hold", data, 16'h1234);
    oe = 1'b0;
    #1;
    check("rd1_data_rel", data, REL);
    check("rd1_ready_rel", {15'd0, ready}, 16'h1);
    tick();
    check("rd1_idle_ready", {15'd0, ready}, 16'h0);
    check("rd1_idle_match", {13'd0, match}, 16'h0);

    // read ch2 with one wait state
    address = 24'h100abc; oe = 1'b1;
    tick();
    check("rd2_match", {13'd0, match}, 16'h0004);
    tick();
    check("rd2_ready_e2", {15'd0, ready}, 16'h0);
    tick();
    check("rd2_ready_e3", {15'd0, ready}, 16'h1);
    check("rd2_data", data, 16'hbeef);
    oe = 1'b0;
    tick();
    check("rd2_idle", {15'd0, ready}, 16'h0);

    // unmapped read
    address = 24'h200000; oe = 1'b1;
    tick();
    check("um_ready", {15'd0, ready}, 16'h1);
    check("um_error", {15'd0, error}, 16'h1);
    check("um_match", {13'd0, match}, 16'h0);
    check("um_data", data, REL);
    check("um_load", {13'd0, load_out}, 16'h0);
    oe = 1'b0;
    tick();
    check("um_clr_error", {15'd0, error}, 16'h0);
    check("um_clr_ready", {15'd0, ready}, 16'h0);

    // both requests at once
    address = 24'h03f000; le = 1'b1; oe = 1'b1;
    tick();
    check("both_error", {15'd0, error}, 16'h1);
    check("both_match", {13'd0, match}, 16'h0);
    check("both_ready", {15'd0, ready}, 16'h1);
    tick();
    check("both_hold_error", {15'd0, error}, 16'h1);
    le = 1'b0; oe = 1'b0;
    tick();
    check("both_clr", {15'd0, ready}, 16'h0);
    check("both_lo0_cnt", 16'(lo_cnt[0]), 16'd1);

    // reset while a ch1 write waits
    address = 24'h03c000; tb_wdata = 16'h7777; tb_drv = 1'b1; le = 1'b1;
    tick();
    check("rw_match", {13'd0, match}, 16'h0002);
    check("rw_dts", dts, 16'h7777);
    tb_drv = 1'b0; reset = 1'b0;
    tick();
    check("rw_rst_match", {13'd0, match}, 16'h0);
    check("rw_rst_load", {13'd0, load_out}, 16'h0);
    check("rw_rst_ready", {15'd0, ready}, 16'h0);
    check("rw_rst_error", {15'd0, error}, 16'h0);
    check("rw_rst_dts", dts, 16'h0);
    check("rw_rst_data", data, REL);
    le = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    check("rw_lo1_cnt", 16'(lo_cnt[1]), 16'd0);
    address = 24'h03f000; oe = 1'b1;
    tick();
    check("rw_rd_ready_e1", {15'd0, ready}, 16'h0);
    tick();
    check("rw_rd_ready_e2", {15'd0, ready}, 16'h1);
    check("rw_rd_data", data, 16'hdead);
    oe = 1'b0;
    tick();

    // write to ch1, which is read-only when protection is built in
    address = 24'h03c000; tb_wdata = 16'h0F0F; tb_drv = 1'b1; le = 1'b1;
    tick();
    check("wp_match", {13'd0, match}, 16'h0002);
`ifdef BUS_SWITCH_WRITE_PROTECT_EN
    check("wp_error", {15'd0, error}, 16'h1);
    check("wp_ready", {15'd0, ready}, 16'h1);
    check("wp_load", {13'd0, load_out}, 16'h0);
    le = 1'b0; tb_drv = 1'b0;
    tick();
    check("wp_lo1_cnt", 16'(lo_cnt[1]), 16'd0);
`else
    check("wp_ready_e1", {15'd0, ready}, 16'h0);
    tick(); tick();
    check("wp_load", {13'd0, load_out}, 16'h0002);
    tick();
    check("wp_ready", {15'd0, ready}, 16'h1);
    check("wp_error", {15'd0, error}, 16'h0);
    le = 1'b0; tb_drv = 1'b0;
    tick();
    check("wp_lo1_cnt", 16'(lo_cnt[1]), 16'd1);
    check("wp_dts", dts, 16'h0F0F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
